// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the default baud divisor.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  localparam int OVERSAMPLE   = 16;
  localparam int MID_SAMPLE   = 7;
  localparam int DVSR_DEFAULT = 651;
endpackage

// File: rtl/baud_generator.sv
// Free-running divider producing a one-clk tick every DVSR clocks; drives the
// receiver's s_tick at 16x the baud rate.
module baud_generator
  import uart_pkg::*;
#(
  parameter int DVSR = DVSR_DEFAULT
) (
  input  logic clk,
  input  logic arst_n,
  output logic tick
);
  localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                cnt <= '0;
    else if (cnt == CW'(DVSR-1)) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == CW'(DVSR-1));
endmodule

// File: rtl/receiver_4.sv
// UART receiver, 16x oversampled, LSB first, with framing-error detection.
// Define RECEIVER_4_RX_SYNC_EN to put rx through a 2-flop synchronizer.
module receiver_4
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            PRESETn,
  input  logic            rx_en,
  input  logic            rx_rst,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            rx_error_tick,
  output logic            rx_busy
);
  localparam int SW = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  state_t          state, state_nxt;
  logic [SW-1:0]   s, s_nxt;
  logic [NW-1:0]   n, n_nxt;
  logic [DBIT-1:0] b, b_nxt, dout_nxt;
  logic            done_nxt, err_nxt;
  logic            rx_i;

`ifdef RECEIVER_4_RX_SYNC_EN
  logic [1:0] rx_sync;
  // Resets to the idle-high line level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge PRESETn) begin
    if (!PRESETn) rx_sync <= 2'b11;
    else          rx_sync <= {rx_sync[0], rx};
  end
  assign rx_i = rx_sync[1];
`else
  assign rx_i = rx;
`endif

  always_ff @(posedge clk or negedge PRESETn) begin
    if (!PRESETn) begin
      state         <= IDLE;
      s             <= '0;
      n             <= '0;
      b             <= '0;
      dout          <= '0;
      rx_done_tick  <= 1'b0;
      rx_error_tick <= 1'b0;
    end else begin
      state         <= state_nxt;
      s             <= s_nxt;
      n             <= n_nxt;
      b             <= b_nxt;
      dout          <= dout_nxt;
      rx_done_tick  <= done_nxt;
      rx_error_tick <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    n_nxt     = n;
    b_nxt     = b;
    dout_nxt  = dout;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (rx_rst) begin
      state_nxt = IDLE;
      s_nxt     = '0;
      n_nxt     = '0;
      b_nxt     = '0;
    end else begin
      case (state)
        IDLE:
          if (rx_en && !rx_i) begin
            state_nxt = START;
            s_nxt     = '0;
          end
        START:
          if (s_tick) begin
            if (s == SW'(MID_SAMPLE)) begin
              // A start bit that is high again at mid-bit is a glitch.
              if (!rx_i) begin
                state_nxt = DATA;
                s_nxt     = '0;
                n_nxt     = '0;
              end else begin
                state_nxt = IDLE;
              end
            end else begin
              s_nxt = s + 1'b1;
            end
          end
        DATA:
          if (s_tick) begin
            if (s == SW'(OVERSAMPLE-1)) begin
              b_nxt = {rx_i, b[DBIT-1:1]};
              s_nxt = '0;
              if (n == NW'(DBIT-1)) state_nxt = STOP;
              else                  n_nxt     = n + 1'b1;
            end else begin
              s_nxt = s + 1'b1;
            end
          end
        STOP:
          if (s_tick) begin
            if (s == SW'(SB_TICK-1)) begin
              s_nxt = '0;
              if (rx_i) begin
                dout_nxt  = b;
                done_nxt  = 1'b1;
                state_nxt = IDLE;
              end else begin
                err_nxt   = 1'b1;
                state_nxt = BREAK;
              end
            end else begin
              s_nxt = s + 1'b1;
            end
          end
        BREAK:
          if (rx_i) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    rx_busy = (state != IDLE);
  end
endmodule

// File: tb/tb_receiver_4.sv
// Directed bench for receiver_4 plus a standalone baud_generator check.
module tb_receiver_4;
  logic       clk = 1'b0;
  logic       PRESETn = 1'b0;
  logic       rx_en = 1'b1;
  logic       rx_rst = 1'b0;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic [7:0] dout;
  logic       done, err, busy, btick;

  receiver_4 #(.DBIT(8), .SB_TICK(16)) dut (
    .clk(clk), .PRESETn(PRESETn), .rx_en(rx_en), .rx_rst(rx_rst), .rx(rx),
    .s_tick(s_tick), .dout(dout), .rx_done_tick(done), .rx_error_tick(err),
    .rx_busy(busy)
  );

  baud_generator #(.DVSR(651)) u_baud (.clk(clk), .arst_n(PRESETn), .tick(btick));

  always #5 clk = ~clk;

  int total = 0, passed = 0;
  int cyc = 0, last_tick = -1, n_int = 0, bad_int = 0;
  int done_cnt = 0, err_cnt = 0, done_wide = 0, err_wide = 0;
  logic pd = 1'b0, pe = 1'b0, pt = 1'b0;
  bit busy_seen = 0;

  always @(negedge clk) begin
    cyc++;
    if (done) done_cnt++;
    if (err)  err_cnt++;
    if (done && pd) done_wide++;
    if (err && pe)  err_wide++;
    if (busy) busy_seen = 1;
    if (btick) begin
      if (pt) bad_int++;
      if (last_tick >= 0) begin
        n_int++;
        if (cyc - last_tick != 651) bad_int++;
      end
      last_tick = cyc;
    end
    pd = done; pe = err; pt = btick;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick_n(input int k);
    repeat (k) begin
      @(negedge clk) s_tick = 1'b1;
      @(negedge clk) s_tick = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic send_bits(input logic [7:0] d, input int nbits);
    rx = 1'b0;
    tick_n(16);
    for (int i = 0; i < nbits; i++) begin
      rx = d[i];
      tick_n(16);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop);
    send_bits(d, 8);
    rx = stop;
    tick_n(16);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         stop;
    bit         en;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vt[6];
  int   d0, e0;

  initial begin
    vt[0] = '{8'h55, 1'b1, 1'b1, 1, 0, 8'h55};
    vt[1] = '{8'hF1, 1'b1, 1'b1, 1, 0, 8'hF1};
    vt[2] = '{8'hA3, 1'b1, 1'b1, 1, 0, 8'hA3};
    vt[3] = '{8'h3C, 1'b0, 1'b1, 0, 1, 8'hA3};
    vt[4] = '{8'h81, 1'b1, 1'b1, 1, 0, 8'h81};
    vt[5] = '{8'h5A, 1'b1, 1'b0, 0, 0, 8'h81};

    #12;
    check("reset_dout", dout, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_btick", btick, 1'b0);
    @(negedge clk) PRESETn = 1'b1;
    tick_n(2);

    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt; e0 = err_cnt; busy_seen = 0;
      rx_en = vt[i].en;
      send_frame(vt[i].d, vt[i].stop);
      if (!vt[i].stop) begin
        tick_n(3);
        check($sformatf("v%0d_busy_held_low", i), busy, 1'b1);
        rx = 1'b1;
      end
      tick_n(2);
      rx_en = 1'b1;
      check($sformatf("v%0d_done", i), done_cnt - d0, vt[i].exp_done);
      check($sformatf("v%0d_err", i), err_cnt - e0, vt[i].exp_err);
      check($sformatf("v%0d_dout", i), dout, vt[i].exp_dout);
      check($sformatf("v%0d_busy_idle", i), busy, 1'b0);
      if (!vt[i].en) check($sformatf("v%0d_busy_seen", i), busy_seen, 1'b0);
    end

    // Start-bit glitch: low for 4 ticks only.
    d0 = done_cnt; e0 = err_cnt; busy_seen = 0;
    rx = 1'b0;
    tick_n(4);
    rx = 1'b1;
    tick_n(6);
    check("glitch_busy_seen", busy_seen, 1'b1);
    check("glitch_busy_end", busy, 1'b0);
    check("glitch_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

    // Soft reset during data bit 3, then a clean frame.
    send_bits(8'h96, 3);
    rx = 1'b0;
    tick_n(5);
    check("rst_busy_before", busy, 1'b1);
    rx_rst = 1'b1;
    rx = 1'b1;
    @(negedge clk) rx_rst = 1'b0;
    check("rst_busy_after", busy, 1'b0);
    check("rst_dout_kept", dout, 8'h81);
    tick_n(2);
    d0 = done_cnt;
    send_frame(8'hC3, 1'b1);
    tick_n(2);
    check("post_rst_done", done_cnt - d0, 1);
    check("post_rst_dout", dout, 8'hC3);

    check("done_pulse_width", done_wide, 0);
    check("err_pulse_width", err_wide, 0);
    check("baud_intervals_seen", (n_int >= 3), 1'b1);
    check("baud_bad_intervals", bad_int, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
